// File: rtl/mc_controller.sv
// Multicycle MIPS control unit (Moore FSM) driving the shared-ALU datapath.
// Optional feature: define MCCTRL_MEMWAIT_EN to add the mem_ready handshake;
// FETCH, MEMRD and MEMWR then stall until memory signals ready.
module mc_controller #(
   parameter int unsigned ALUCTL_W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          op,
   input  logic [5:0]          funct,
   input  logic                zero,
`ifdef MCCTRL_MEMWAIT_EN
   input  logic                mem_ready,
`endif
   output logic                iord,
   output logic                memwrite,
   output logic                irwrite,
   output logic                regdst,
   output logic                memtoreg,
   output logic                link,
   output logic                regwrite,
   output logic                alusrca,
   output logic [1:0]          alusrcb,
   output logic [1:0]          pcsrc,
   output logic                pcen,
   output logic [ALUCTL_W-1:0] alucontrol,
   output logic                illegal
);

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpJal   = 6'b000011;
   localparam logic [5:0] FnJr    = 6'b001000;

   localparam logic [2:0] AluAnd = 3'b000;
   localparam logic [2:0] AluOr  = 3'b001;
   localparam logic [2:0] AluAdd = 3'b010;
   localparam logic [2:0] AluSub = 3'b110;
   localparam logic [2:0] AluSlt = 3'b111;

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StRtypeEx,
      StRtypeWb, StBrEx, StAddiEx, StAddiWb, StJEx, StJalEx, StJrEx
   } state_t;

   state_t     state_q, state_d;
   logic       ready;
   logic       pcwrite;
   logic       branch;
   logic [2:0] alu_op;

`ifdef MCCTRL_MEMWAIT_EN
   assign ready = mem_ready;
`else
   assign ready = 1'b1;
`endif

   // Codes are zero-extended into any extra upper alucontrol bits.
   assign alucontrol = ALUCTL_W'(alu_op);

   // Next-state decode; memory states hold until the memory is ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch:   if (ready) state_d = StDecode;
         StDecode: begin
            case (op)
               OpLw, OpSw:   state_d = StMemAdr;
               OpRtype:      state_d = (funct == FnJr) ? StJrEx : StRtypeEx;
               OpBeq, OpBne: state_d = StBrEx;
               OpAddi:       state_d = StAddiEx;
               OpJ:          state_d = StJEx;
               OpJal:        state_d = StJalEx;
               default:      state_d = StFetch;
            endcase
         end
         StMemAdr:  state_d = (op == OpSw) ? StMemWr : StMemRd;
         StMemRd:   if (ready) state_d = StMemWb;
         StMemWr:   if (ready) state_d = StFetch;
         StRtypeEx: state_d = StRtypeWb;
         StAddiEx:  state_d = StAddiWb;
         default:   state_d = StFetch;
      endcase
   end

   // State register; reset lands in FETCH immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StFetch;
      else       state_q <= state_d;
   end

   // Output decode from state (plus op/funct/zero where the state needs them).
   always_comb begin
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      link     = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      alu_op   = AluAnd;
      illegal  = 1'b0;
      case (state_q)
         StFetch: begin
            irwrite = ready;
            pcwrite = ready;
            alusrcb = 2'b01;
            alu_op  = AluAdd;
         end
         StDecode: begin
            alusrcb = 2'b11;
            alu_op  = AluAdd;
            illegal = !(op inside {OpRtype, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpJ, OpJal});
         end
         StMemAdr, StAddiEx: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            alu_op  = AluAdd;
         end
         StMemRd: iord = 1'b1;
         StMemWb: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         StMemWr: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         StRtypeEx: begin
            alusrca = 1'b1;
            case (funct)
               6'b100000: alu_op = AluAdd;
               6'b100010: alu_op = AluSub;
               6'b100100: alu_op = AluAnd;
               6'b100101: alu_op = AluOr;
               6'b101010: alu_op = AluSlt;
               default: begin
                  alu_op  = AluAdd;
                  illegal = 1'b1;
               end
            endcase
         end
         StRtypeWb: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         StBrEx: begin
            alusrca = 1'b1;
            alu_op  = AluSub;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         StAddiWb: regwrite = 1'b1;
         StJEx: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         StJalEx: begin
            link     = 1'b1;
            regwrite = 1'b1;
            pcsrc    = 2'b10;
            pcwrite  = 1'b1;
         end
         StJrEx: begin
            pcsrc   = 2'b11;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
      pcen = pcwrite | (branch & (zero ^ (op == OpBne)));
      // Strobes are forced off while reset is held so nothing is written.
      if (reset) begin
         memwrite = 1'b0;
         irwrite  = 1'b0;
         regwrite = 1'b0;
         pcen     = 1'b0;
         illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction phase model plus
// literal spot checks and cycles-per-instruction checks.
module tb_mc_controller;

   localparam int W = 4;

   typedef struct packed {
      logic         iord;
      logic         memwrite;
      logic         irwrite;
      logic         regdst;
      logic         memtoreg;
      logic         link;
      logic         regwrite;
      logic         alusrca;
      logic [1:0]   alusrcb;
      logic [1:0]   pcsrc;
      logic         pcen;
      logic [W-1:0] alucontrol;
      logic         illegal;
   } outs_t;

   typedef enum int {
      PFetch, PDecode, PMemAdr, PMemRd, PMemWb, PMemWr, PRex, PRwb, PBr,
      PAex, PAwb, PJ, PJal, PJr
   } ph_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [5:0]   op, funct;
   logic         zero;
`ifdef MCCTRL_MEMWAIT_EN
   logic         mem_ready;
`endif
   logic         iord, memwrite, irwrite, regdst, memtoreg, link, regwrite, alusrca;
   logic [1:0]   alusrcb, pcsrc;
   logic         pcen, illegal;
   logic [W-1:0] alucontrol;

   outs_t act, exp_o, lit_mask, lit_val;
   logic  chk_en = 1'b0;
   logic  lit_en = 1'b0;
   int    gap_exp = 0;
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    last_ir = 0;

   mc_controller #(.ALUCTL_W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
`ifdef MCCTRL_MEMWAIT_EN
      .mem_ready  (mem_ready),
`endif
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .link       (link),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .pcen       (pcen),
      .alucontrol (alucontrol),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   assign act = {iord, memwrite, irwrite, regdst, memtoreg, link, regwrite, alusrca,
                 alusrcb, pcsrc, pcen, alucontrol, illegal};

   // Expected outputs for one cycle of a phase, straight from the state table.
   function automatic outs_t model(ph_t p, logic [5:0] o, logic [5:0] f, logic z, logic r);
      outs_t e;
      e = '0;
      case (p)
         PFetch:  begin e.irwrite = r; e.pcen = r; e.alusrcb = 2'b01; e.alucontrol = W'(2); end
         PDecode: begin
            e.alusrcb = 2'b11; e.alucontrol = W'(2);
            e.illegal = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                    6'b000101, 6'b001000, 6'b000010, 6'b000011});
         end
         PMemAdr, PAex: begin e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = W'(2); end
         PMemRd:  e.iord = 1;
         PMemWb:  begin e.memtoreg = 1; e.regwrite = 1; end
         PMemWr:  begin e.iord = 1; e.memwrite = 1; end
         PRex: begin
            e.alusrca = 1;
            case (f)
               6'b100000: e.alucontrol = W'(2);
               6'b100010: e.alucontrol = W'(6);
               6'b100100: e.alucontrol = W'(0);
               6'b100101: e.alucontrol = W'(1);
               6'b101010: e.alucontrol = W'(7);
               default:   begin e.alucontrol = W'(2); e.illegal = 1; end
            endcase
         end
         PRwb:    begin e.regdst = 1; e.regwrite = 1; end
         PBr: begin
            e.alusrca = 1; e.alucontrol = W'(6); e.pcsrc = 2'b01;
            e.pcen = (o == 6'b000101) ? !z : z;
         end
         PAwb:    e.regwrite = 1;
         PJ:      begin e.pcsrc = 2'b10; e.pcen = 1; end
         PJal:    begin e.link = 1; e.regwrite = 1; e.pcsrc = 2'b10; e.pcen = 1; end
         PJr:     begin e.pcsrc = 2'b11; e.pcen = 1; end
         default: ;
      endcase
      return e;
   endfunction

   function automatic outs_t reset_vec();
      outs_t e;
      e = '0;
      e.alusrcb = 2'b01;
      e.alucontrol = W'(2);
      return e;
   endfunction

   // Hand-written cycles-per-instruction table (no memory stalls).
   function automatic int cpi_lit(logic [5:0] o, logic [5:0] f);
      case (o)
         6'b100011:                       return 5;
         6'b101011, 6'b001000:            return 4;
         6'b000000:                       return (f == 6'b001000) ? 3 : 4;
         6'b000100, 6'b000101,
         6'b000010, 6'b000011:            return 3;
         default:                         return 2;
      endcase
   endfunction

   // Runs one instruction; abort_at>0 asserts reset in that cycle instead.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input bit rnd, input int wr_stall, input int lit_cyc,
                            input outs_t lm, input outs_t lv, input int abort_at);
      ph_t  seq[$];
      int   n, st, stalls, guard;
      logic r;
      n = 0; st = 0; stalls = 0;
      op = o; funct = f; zero = z;
      seq.push_back(PFetch);
      seq.push_back(PDecode);
      case (o)
         6'b100011: begin seq.push_back(PMemAdr); seq.push_back(PMemRd); seq.push_back(PMemWb); end
         6'b101011: begin seq.push_back(PMemAdr); seq.push_back(PMemWr); end
         6'b000000: if (f == 6'b001000) seq.push_back(PJr);
                    else begin seq.push_back(PRex); seq.push_back(PRwb); end
         6'b000100, 6'b000101: seq.push_back(PBr);
         6'b001000: begin seq.push_back(PAex); seq.push_back(PAwb); end
         6'b000010: seq.push_back(PJ);
         6'b000011: seq.push_back(PJal);
         default: ;
      endcase
      foreach (seq[i]) begin
         guard = 0;
         do begin
            r = 1'b1;
`ifdef MCCTRL_MEMWAIT_EN
            if (rnd && guard < 4 && seq[i] inside {PFetch, PMemRd, PMemWr})
               r = ($urandom_range(0, 2) != 0);
`endif
            if (seq[i] == PMemWr && st < wr_stall) begin r = 1'b0; st++; end
`ifdef MCCTRL_MEMWAIT_EN
            mem_ready = r;
`endif
            n++;
            if (n == abort_at) begin
               reset = 1'b1;
               exp_o = reset_vec();
               lit_en = 1'b0;
               gap_exp = 0;
               repeat (2) begin @(posedge clk); #1; end
               reset = 1'b0;
               return;
            end
            exp_o = model(seq[i], o, f, z, r);
            lit_en = (n == lit_cyc);
            lit_mask = lm;
            lit_val = lv;
            @(posedge clk); #1;
            if (!r && seq[i] != PFetch) stalls++;
            guard++;
         end while (!r);
      end
      lit_en = 1'b0;
      gap_exp = rnd ? 0 : cpi_lit(o, f) + stalls;
   endtask

   // Single checker: full vector vs model, literal spot checks, and CPI.
   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         total++;
         if (act !== exp_o) begin
            bad++;
            $display("FAIL vec t=%0t op=%b funct=%b act=%h exp=%h", $time, op, funct, act, exp_o);
         end
         if (lit_en) begin
            total++;
            if ((act & lit_mask) !== lit_val) begin
               bad++;
               $display("FAIL lit t=%0t op=%b act=%h exp=%h mask=%h", $time, op,
                        act & lit_mask, lit_val, lit_mask);
            end
         end
         if (irwrite === 1'b1) begin
            if (gap_exp != 0) begin
               total++;
               if (cyc - last_ir != gap_exp) begin
                  bad++;
                  $display("FAIL cpi t=%0t act=%0d exp=%0d", $time, cyc - last_ir, gap_exp);
               end
            end
            last_ir = cyc;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t act=running exp=finished", $time);
      $fatal(1, "timeout");
   end

   initial begin
      outs_t m, v;
      logic [5:0] ops[10];
      logic [5:0] fns[7];
      logic [5:0] o, f;
      ops = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
              6'b001000, 6'b000010, 6'b000011, 6'b111111};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000, 6'b000000};
      reset = 1'b0; op = 6'b100011; funct = '0; zero = 1'b0;
`ifdef MCCTRL_MEMWAIT_EN
      mem_ready = 1'b1;
`endif
      #1 reset = 1'b1;
      exp_o = reset_vec();
      chk_en = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b0;

      // lw: register write from memory in cycle 5
      m = '0; v = '0; m.regwrite = 1; m.memtoreg = 1; v.regwrite = 1; v.memtoreg = 1;
      run_instr(6'b100011, 6'b000000, 1'b0, 0, 0, 5, m, v, 0);
      // beq taken, bne not taken with zero=1
      m = '0; v = '0; m.pcen = 1; m.pcsrc = 2'b11; v.pcen = 1; v.pcsrc = 2'b01;
      run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 3, m, v, 0);
      m = '0; v = '0; m.pcen = 1;
      run_instr(6'b000101, 6'b000000, 1'b1, 0, 0, 3, m, v, 0);
      // slt, then jr
      m = '0; v = '0; m.alucontrol = '1; v.alucontrol = 4'b0111;
      run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, 3, m, v, 0);
      m = '0; v = '0; m.pcsrc = 2'b11; m.pcen = 1; m.regwrite = 1; v.pcsrc = 2'b11; v.pcen = 1;
      run_instr(6'b000000, 6'b001000, 1'b0, 0, 0, 3, m, v, 0);
      // jal
      m = '0; v = '0; m.link = 1; m.regwrite = 1; m.pcsrc = 2'b11; m.pcen = 1;
      v.link = 1; v.regwrite = 1; v.pcsrc = 2'b10; v.pcen = 1;
      run_instr(6'b000011, 6'b000000, 1'b0, 0, 0, 3, m, v, 0);
      // illegal opcode: flag only, no strobes
      m = '0; v = '0; m.illegal = 1; m.memwrite = 1; m.regwrite = 1; m.irwrite = 1; m.pcen = 1;
      v.illegal = 1;
      run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 2, m, v, 0);
      m = '0; v = '0;
      run_instr(6'b001000, 6'b000000, 1'b0, 0, 0, 0, m, v, 0);
`ifdef MCCTRL_MEMWAIT_EN
      // sw with two not-ready cycles in MEMWR: 6 cycles total
      run_instr(6'b101011, 6'b000000, 1'b0, 0, 2, 0, m, v, 0);
`endif
      run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 0, m, v, 0);
      // reset in the MEMRD cycle of a lw aborts it
      run_instr(6'b100011, 6'b000000, 1'b0, 0, 0, 0, m, v, 4);

      for (int k = 0; k < 300; k++) begin
         o = ops[$urandom_range(0, 9)];
         f = fns[$urandom_range(0, 6)];
         if (o == 6'b111111) o = 6'($urandom);
         if (f == 6'b000000) f = 6'($urandom);
         run_instr(o, f, 1'($urandom), 1, 0, 0, m, v, 0);
      end

      chk_en = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle MIPS control unit: a Moore FSM that sequences each instruction over 3–5 cycles through a shared ALU and a unified instruction/data memory. It sits beside the multicycle datapath in place of the single-cycle controller and drives its mux selects, register write enables and PC enable. It covers the same instruction set (R-type, lw, sw, beq/bne, addi, j, jal, jr), with a parametrised ALU-control width, an illegal-opcode flag and an optional memory wait handshake.

## Interface
- ALUCTL_W, 3: alucontrol width; must be ≥3. Codes are zero-extended into the upper bits.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- op  in  6  opcode field of the instruction register
- funct  in  6  funct field of the instruction register
- zero  in  1  ALU zero flag (valid in the branch state)
- mem_ready  in  1  memory ready (present only with MCCTRL_MEMWAIT_EN)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  write register select: 1 = rd, 0 = rt
- memtoreg  out  1  register write data select: 1 = Data register, 0 = ALUOut
- link  out  1  forces write register to 31 and write data to PC (jal)
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = A register
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = A register (jr)
- pcen  out  1  PC load enable
- alucontrol  out  ALUCTL_W  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  one-cycle pulse on an undecodable instruction

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BREX, ADDIEX, ADDIWB, JEX, JALEX, JREX.
- FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, add, pcsrc=00, pcwrite → DECODE.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Dispatch:
  - lw/sw (100011/101011) → MEMADR
  - R-type (000000), funct≠001000 → RTYPEEX
  - R-type with funct 001000 (jr) → JREX
  - beq/bne (000100/000101) → BREX
  - addi (001000) → ADDIEX
  - j (000010) → JEX
  - jal (000011) → JALEX
  - anything else: illegal=1 → FETCH
- MEMADR: alusrca=1, alusrcb=10, add → MEMRD (lw) or MEMWR (sw).
- MEMRD: iord=1 → MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite → FETCH.
- MEMWR: iord=1, memwrite → FETCH.
- RTYPEEX: alusrca=1, alusrcb=00. funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct gives add and pulses illegal → RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite → FETCH.
- BREX: alusrca=1, alusrcb=00, sub, pcsrc=01. pcen = zero (beq) or ~zero (bne) → FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add → ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite → FETCH.
- JEX: pcsrc=10, pcwrite → FETCH.
- JALEX: link=1, regwrite, pcsrc=10, pcwrite → FETCH. Link value is the already-incremented PC (PC+4).
- JREX: pcsrc=11, pcwrite → FETCH.
- pcen = pcwrite | (branch & (zero ^ isbne)). pcwrite and branch are internal.
- Any output not listed for a state is 0.

## Timing
- Next state registers on rising clk. Outputs are combinational from the state, plus funct in RTYPEEX, op in DECODE/MEMADR/BREX, and zero in BREX.
- Cycles per instruction: lw 5; sw, R-type, addi 4; beq, bne, j, jal, jr 3; illegal 2.
- Reset: state = FETCH immediately. While reset is high, memwrite, irwrite, regwrite, pcen and illegal are 0. Other outputs hold their FETCH values: iord 0, alusrca 0, alusrcb 01, alucontrol 010, pcsrc 00, the rest 0.
- Reset asserted mid-instruction aborts it. No partial writes occur after the reset edge.
- The first FETCH executes in the first cycle after reset deasserts.

## Configuration
- MCCTRL_MEMWAIT_EN defined: the mem_ready port exists.
  - FETCH, MEMRD and MEMWR hold state while mem_ready=0.
  - In FETCH, irwrite and pcwrite are asserted only in the cycle mem_ready=1.
  - In MEMWR, memwrite stays high until the mem_ready=1 cycle.
  - MEMRD advances only when mem_ready=1.
- Undefined: no mem_ready port; every memory state lasts exactly one cycle.

## Test plan
- Reset held 3 cycles then released, op=100011 → pcen/irwrite 0 during reset; irwrite=1 in cycle 1 after release; regwrite with memtoreg=1 on cycle 5; back in FETCH on cycle 6.
- beq with zero=1, then bne with zero=1 → pcen=1, pcsrc=01 in BREX for beq; pcen=0 for bne; both take 3 cycles.
- R-type funct 101010, then funct 001000 → alucontrol=111 in RTYPEEX and regwrite+regdst in RTYPEWB; jr gives pcsrc=11, pcen=1, regwrite=0 in its third cycle.
- jal (op 000011) → third cycle: link=1, regwrite=1, pcsrc=10, pcen=1.
- op=111111 → illegal=1 for exactly one cycle in DECODE, no write strobe asserted, FETCH next.
- With MCCTRL_MEMWAIT_EN, sw with mem_ready low 2 cycles in MEMWR → memwrite high 3 cycles; instruction takes 6 cycles total (mem_ready=1 in FETCH).
